cmp_window_stats: RTL and testbench
===================================

Name: cmp_window_stats

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator. Consumes its equal/greater/less flags together with the operand pair that produced them.
- Over a programmable window of accepted samples it counts equal, greater and less outcomes, and tracks the peak |A-B|. It also flags illegal (non-one-hot) flag combinations.
- Results are held for the ALU status/readout logic until the next window starts.

Parameters:
- WIDTH, 4, operand width; matches comparator input width.
- WINDOW, 8, number of accepted samples per window; legal range 1..255.
- CW, 8, counter width; must satisfy 2**CW > WINDOW.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin new window; honoured only in IDLE.
- in_valid  in  1  sample strobe; operands and flags valid this cycle.
- in_a  in  WIDTH  operand A as presented to comparator.
- in_b  in  WIDTH  operand B as presented to comparator.
- in_equal  in  1  comparator equal flag.
- in_greater  in  1  comparator greater flag (A>B).
- in_less  in  1  comparator less flag (A<B).
- busy  out  1  high while in COLLECT.
- done  out  1  one-cycle pulse when window completes.
- cnt_eq  out  CW  equal outcomes in current/last window.
- cnt_gt  out  CW  greater outcomes.
- cnt_lt  out  CW  less outcomes.
- cnt_err  out  CW  samples whose flags were not exactly one-hot.
- max_diff  out  WIDTH  largest |A-B| among legal samples.

Behaviour:
- Clock and reset are fixed: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0; all counters=0; max_diff=0. Reset wins over every other input in the same cycle.
- FSM states: IDLE, COLLECT, DONE. All outputs are registered; no combinational input-to-output path.
- IDLE:
  - start=1 -> next edge: clear all counters, max_diff and the internal sample count; go to COLLECT.
  - in_valid is ignored in IDLE, including in the same cycle as start.
- COLLECT: a sample is accepted on any edge with in_valid=1.
  - Exactly one flag high: increment the matching counter. diff = greater ? in_a-in_b : (less ? in_b-in_a : 0), computed in WIDTH bits unsigned (no wrap possible). If diff > max_diff, load max_diff.
  - Flags not one-hot (000, 011, 101, 110, 111): increment cnt_err only. The sample consumes a window slot; max_diff is unchanged.
  - Internal sample count increments per accepted sample. Counters never exceed WINDOW, so no saturation logic is required.
  - When the accepted sample is the WINDOW-th: counters update on that edge and state goes to DONE on the same edge.
  - start is ignored in COLLECT. No abort exists; only rst terminates a window.
- DONE: done=1 for exactly this one cycle, then unconditionally IDLE. in_valid and start are ignored in DONE.
- busy=1 iff state==COLLECT.
- Results hold after DONE until the next accepted start, which clears them one edge later.
- Latency: done rises one cycle after the edge accepting the last sample. Minimum turnaround start->start is WINDOW+2 cycles with back-to-back in_valid.
- Reset mid-COLLECT: partial results are discarded, all outputs zero, next cycle IDLE.
- Invariant at done: cnt_eq+cnt_gt+cnt_lt+cnt_err == WINDOW.

Decomposition:
- Shared package alu_pkg: state encoding constants (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2), the default WIDTH, and the flag-legality function (one-hot check).
- One natural sub-module: cmp_abs_diff (combinational |A-B| selected by the greater/less flags, WIDTH-parameterised).
- Counters and FSM stay in the top block.

Test Plan:
- Reset/idle: assert rst 2 cycles, drive in_valid=1 without start -> all outputs 0, busy=0, done never pulses.
- Mixed window (WINDOW=8): start, then 8 back-to-back samples (3,3,eq),(9,2,gt),(1,7,lt),(15,0,gt),(4,4,eq),(0,5,lt),(6,1,gt),(2,2,eq) -> cnt_eq=3, cnt_gt=3, cnt_lt=2, cnt_err=0, max_diff=15. done pulses exactly 1 cycle, 1 cycle after the 8th sample.
- Illegal flags: window with flag patterns 000 and 110 among 6 legal ones (max legal diff 6, illegal carrying A=15,B=0) -> cnt_err=2, max_diff=6, sum of counters = 8.
- Gapped valid plus ignored starts: in_valid toggling 1/0, start pulsed mid-COLLECT and in DONE -> window still ends after 8 accepted samples; counts are not cleared by the ignored starts.
- Reset mid-operation: rst after 5 samples -> next cycle all counters 0, busy=0. A fresh start then yields correct counts for a new 8-sample window.
- Boundary WINDOW=1: start, single (0,15,lt) sample -> cnt_lt=1, max_diff=15, done on the following cycle, busy high for exactly 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the comparator back-end: state encoding, default width
// and the comparator flag legality check.
package alu_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // True when exactly one of equal/greater/less is asserted.
    function automatic logic flags_one_hot(input logic eq, input logic gt, input logic lt);
        logic ok;
        case ({eq, gt, lt})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cmp_abs_diff.sv
// Combinational |A-B|, with the subtraction direction chosen by the comparator
// flags so the result never wraps.
module cmp_abs_diff #(
    parameter int unsigned WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             greater_i,
    input  logic             less_i,
    output logic [WIDTH-1:0] diff_c_o
);

    always_comb begin
        diff_c_o = '0;
        if (greater_i) begin
            diff_c_o = a_i - b_i;
        end else if (less_i) begin
            diff_c_o = b_i - a_i;
        end
    end

endmodule

// File: rtl/cmp_window_stats.sv
// Windowed statistics over comparator outcomes: per-flag counts, illegal flag
// count and peak |A-B|, held for readout until the next window starts.
module cmp_window_stats
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_equal,
    input  logic             in_greater,
    input  logic             in_less,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    cnt_eq,
    output logic [CW-1:0]    cnt_gt,
    output logic [CW-1:0]    cnt_lt,
    output logic [CW-1:0]    cnt_err,
    output logic [WIDTH-1:0] max_diff
);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    smp_q, smp_d;
    logic [CW-1:0]    eq_q, eq_d;
    logic [CW-1:0]    gt_q, gt_d;
    logic [CW-1:0]    lt_q, lt_d;
    logic [CW-1:0]    err_q, err_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] diff_c;
    logic             legal_c;

    cmp_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
        .a_i       (in_a),
        .b_i       (in_b),
        .greater_i (in_greater),
        .less_i    (in_less),
        .diff_c_o  (diff_c)
    );

    assign legal_c = flags_one_hot(in_equal, in_greater, in_less);

    // Next-state, counter and peak update
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        err_d   = err_q;
        max_d   = max_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    smp_d   = '0;
                    eq_d    = '0;
                    gt_d    = '0;
                    lt_d    = '0;
                    err_d   = '0;
                    max_d   = '0;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    smp_d = smp_q + CW'(1);
                    if (legal_c) begin
                        if (in_equal)   eq_d = eq_q + CW'(1);
                        if (in_greater) gt_d = gt_q + CW'(1);
                        if (in_less)    lt_d = lt_q + CW'(1);
                        if (diff_c > max_q) max_d = diff_c;
                    end else begin
                        err_d = err_q + CW'(1);
                    end
                    if (smp_q == CW'(WINDOW - 1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COLLECT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            smp_q   <= '0;
            eq_q    <= '0;
            gt_q    <= '0;
            lt_q    <= '0;
            err_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            smp_q   <= smp_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            err_q   <= err_d;
            max_q   <= max_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cnt_eq   = eq_q;
    assign cnt_gt   = gt_q;
    assign cnt_lt   = lt_q;
    assign cnt_err  = err_q;
    assign max_diff = max_q;

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed self-checking bench for cmp_window_stats (WINDOW=8 and WINDOW=1 instances).
module tb_cmp_window_stats;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic       in_valid;
    logic [3:0] in_a, in_b;
    logic       in_equal, in_greater, in_less;

    logic       busy, done, busy1, done1;
    logic [7:0] cnt_eq, cnt_gt, cnt_lt, cnt_err;
    logic [7:0] cnt_eq1, cnt_gt1, cnt_lt1, cnt_err1;
    logic [3:0] max_diff, max_diff1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] va [8];
    logic [3:0] vb [8];
    logic [2:0] vf [8];

    always #5 clk = ~clk;

    cmp_window_stats #(.WIDTH(4), .WINDOW(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_equal(in_equal), .in_greater(in_greater),
        .in_less(in_less), .busy(busy), .done(done), .cnt_eq(cnt_eq),
        .cnt_gt(cnt_gt), .cnt_lt(cnt_lt), .cnt_err(cnt_err), .max_diff(max_diff)
    );

    cmp_window_stats #(.WIDTH(4), .WINDOW(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_equal(in_equal), .in_greater(in_greater),
        .in_less(in_less), .busy(busy1), .done(done1), .cnt_eq(cnt_eq1),
        .cnt_gt(cnt_gt1), .cnt_lt(cnt_lt1), .cnt_err(cnt_err1), .max_diff(max_diff1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_equal   = f[2];
        in_greater = f[1];
        in_less    = f[0];
    endtask

    task automatic check_counts(input string tag, input int e, input int g, input int l,
                                input int er, input int m);
        check({tag, "_eq"},  32'(cnt_eq),   32'(e));
        check({tag, "_gt"},  32'(cnt_gt),   32'(g));
        check({tag, "_lt"},  32'(cnt_lt),   32'(l));
        check({tag, "_err"}, 32'(cnt_err),  32'(er));
        check({tag, "_max"}, 32'(max_diff), 32'(m));
    endtask

    // Start a window, feed va/vb/vf back-to-back, checking busy/done each cycle.
    task automatic run_table(input string tag);
        start = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        tick();
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vf[i]);
            tick();
            if (i < 7) begin
                check({tag, "_done_early"}, 32'(done), 32'd0);
                check({tag, "_busy_mid"},   32'(busy), 32'd1);
            end
        end
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_busy_end"},   32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(cnt_eq) + 32'(cnt_gt) + 32'(cnt_lt) + 32'(cnt_err), 32'd8);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'b000);

        // Reset and idle behaviour
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_counts("rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd15, 4'd0, 3'b010);
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        check_counts("idle", 0, 0, 0, 0, 0);

        // Mixed window
        va = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd4, 4'd0, 4'd6, 4'd2};
        vb = '{4'd3, 4'd2, 4'd7, 4'd0,  4'd4, 4'd5, 4'd1, 4'd2};
        vf = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        run_table("mixed");
        check_counts("mixed", 3, 3, 2, 0, 15);
        tick();
        check("mixed_done_drop", 32'(done), 32'd0);
        check_counts("mixed_hold", 3, 3, 2, 0, 15);

        // Illegal flag patterns
        va = '{4'd3, 4'd15, 4'd9, 4'd2, 4'd15, 4'd1, 4'd4, 4'd8};
        vb = '{4'd3, 4'd0,  4'd3, 4'd5, 4'd0,  4'd7, 4'd4, 4'd6};
        vf = '{3'b100, 3'b000, 3'b010, 3'b001, 3'b110, 3'b001, 3'b100, 3'b010};
        run_table("illegal");
        check_counts("illegal", 2, 2, 2, 2, 6);
        tick();

        // Gapped valid with ignored starts mid-window and in DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        va = '{4'd7, 4'd10, 4'd0, 4'd5, 4'd12, 4'd2, 4'd1, 4'd6};
        vb = '{4'd7, 4'd2,  4'd3, 4'd5, 4'd11, 4'd9, 4'd1, 4'd0};
        vf = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, va[i], vb[i], vf[i]);
            tick();
            if (i < 7) begin
                drive(1'b0, 4'd15, 4'd0, 3'b010);
                start = (i == 3);
                tick();
                start = 1'b0;
                check("gap_busy", 32'(busy), 32'd1);
            end
        end
        check("gap_done", 32'(done), 32'd1);
        start = 1'b1;
        drive(1'b1, 4'd15, 4'd0, 3'b010);
        tick();
        start = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        check_counts("gap", 3, 3, 2, 0, 8);
        check("gap_done_drop", 32'(done), 32'd0);
        tick();
        check("gap_start_in_done_ignored", 32'(busy), 32'd0);

        // Reset mid-window, then a fresh window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd3, 4'd1, 3'b010);
            tick();
        end
        check("mid_gt", 32'(cnt_gt), 32'd5);
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check_counts("mid_rst", 0, 0, 0, 0, 0);
        tick();
        check("mid_rst_idle", 32'(busy), 32'd0);
        va = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd4, 4'd0, 4'd6, 4'd2};
        vb = '{4'd3, 4'd2, 4'd7, 4'd0,  4'd4, 4'd5, 4'd1, 4'd2};
        vf = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        run_table("fresh");
        check_counts("fresh", 3, 3, 2, 0, 15);
        tick();

        // WINDOW=1 instance
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        drive(1'b1, 4'd0, 4'd15, 3'b001);
        tick();
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        check("w1_busy_end", 32'(busy1), 32'd0);
        check("w1_done", 32'(done1), 32'd1);
        check("w1_lt", 32'(cnt_lt1), 32'd1);
        check("w1_eq", 32'(cnt_eq1), 32'd0);
        check("w1_gt", 32'(cnt_gt1), 32'd0);
        check("w1_err", 32'(cnt_err1), 32'd0);
        check("w1_max", 32'(max_diff1), 32'd15);
        tick();
        check("w1_done_drop", 32'(done1), 32'd0);
        check("w1_hold", 32'(max_diff1), 32'd15);
        check("w8_idle_untouched", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
